apb_requester: RTL
==================

Name: apb_requester

Overview:
- APB4 requester (master) that drives the PSEL/PENABLE phases seen by the team's APB completer blocks.
- Accepts one transfer command at a time on a valid/ready command port and sequences it through the SETUP and ACCESS phases.
- Returns read data and error status on a one-cycle response strobe.
- Used as the stimulus end in equivalence and integration benches, and as a bridge from internal logic to APB peripherals.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA/PRDATA and the data ports; legal values are 8, 16, 32.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with the optional feature; must be at least 1.

Ports:
- PCLK  in  1  clock; all logic is rising-edge.
- PRESET  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write strobes.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB strobes; driven to 0 on reads.
- PREADY  in  1  completer ready.
- PRDATA  in  DATA_WIDTH  completer read data.
- PSLVERR  in  1  completer error.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_error  out  1  PSLVERR, or timeout when the optional feature is compiled in.
- rsp_timeout  out  1  timeout flag; tied to 0 without the optional feature.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states:
  - IDLE: cmd_ready = 1. On handshake, register write/addr/wdata/strb, go to SETUP.
  - SETUP: PSEL = 1, PENABLE = 0. Unconditionally go to ACCESS next cycle.
  - ACCESS: PSEL = 1, PENABLE = 1. Stay while PREADY = 0. When PREADY = 1, go to IDLE.
- Completion: when PREADY = 1 in ACCESS:
  - capture PRDATA (reads only) and PSLVERR;
  - drive rsp_valid = 1 on the following cycle, alongside the return to IDLE.
- Latency:
  - handshake at cycle N gives PSEL at N+1 and PENABLE at N+2;
  - with zero wait states, rsp_valid is at N+3;
  - the next command is accepted at N+3 at the earliest, so throughput is at most 1 transfer per 3 cycles.
- cmd_ready is high only in IDLE, including the cycle in which rsp_valid is high.
- Signal stability:
  - PADDR, PWRITE, PWDATA and PSTRB are registered and stay stable from SETUP through the completing ACCESS cycle.
  - They hold their last value in IDLE.
  - PENABLE is never high while PSEL is low.
- rsp_rdata and rsp_error are valid only while rsp_valid = 1. They hold their values until the next response.
- PRDATA is ignored on writes.
- PSLVERR is sampled only in the completing cycle. It is ignored at all other times.
- PRESET (synchronous, active-high), effective at the next edge:
  - FSM goes to IDLE;
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_error and rsp_timeout go to 0;
  - PADDR, PWDATA, PSTRB and rsp_rdata go to 0;
  - cmd_ready is 1 from the first cycle after reset deasserts;
  - the output values above are held while PRESET is high.
- Reset mid-transfer aborts the transfer. No rsp_valid is issued for the aborted command.
- A cmd_valid that arrives while the block is busy is not accepted. The source holds it until cmd_ready is high.

Optional Feature:
- Macro: APB_REQUESTER_TIMEOUT_EN.
- With the macro defined:
  - a counter counts ACCESS cycles with PREADY = 0;
  - if TIMEOUT_CYCLES such cycles elapse, the next cycle forces IDLE and deasserts PSEL/PENABLE;
  - rsp_valid = 1 with rsp_error = 1, rsp_timeout = 1 and rsp_rdata = 0;
  - the counter clears on entry to SETUP;
  - if PREADY = 1 arrives in the same cycle the limit is reached, normal completion wins and no timeout is flagged.
- Without the macro: the block waits indefinitely for PREADY, and rsp_timeout is constant 0.

Test Plan:
- Zero-wait write: addr 0x10, wdata 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL rises at N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_error = 0.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, then high with PRDATA 0x12345678 -> ACCESS lasts 4 cycles, rsp_rdata = 0x12345678, and PADDR stays stable throughout.
- Error read: PSLVERR = 1 on the completing cycle -> rsp_error = 1. PSLVERR pulsed while PREADY = 0 -> no effect.
- Back-to-back: cmd_valid held high with 4 commands -> 4 transfers at 3-cycle spacing, and no PENABLE without PSEL.
- Reset in ACCESS: assert PRESET while PREADY = 0 -> next cycle PSEL = PENABLE = 0, no rsp_valid, cmd_ready = 1 after release.
- APB_REQUESTER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, PREADY stuck at 0 -> after 4 ACCESS cycles, rsp_valid with rsp_error = rsp_timeout = 1 and the FSM in IDLE.

Source files
------------

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : apb_requester
// Purpose  : APB4 requester. Takes one transfer command at a time on a
//            valid/ready port, runs it through the APB SETUP and ACCESS
//            phases, and returns read data and error status on a one-cycle
//            response strobe.
// Ports    : PCLK/PRESET         - rising-edge clock, synchronous active-high reset
//            cmd_*               - command port (valid/ready handshake)
//            PSEL..PSTRB         - APB request signals
//            PREADY/PRDATA/PSLVERR - APB completer response
//            rsp_*               - response strobe, read data, error, timeout
//            busy                - high whenever a transfer is in progress
// Options  : APB_REQUESTER_TIMEOUT_EN - abort an ACCESS phase that has waited
//            TIMEOUT_CYCLES cycles without PREADY. Undefined: wait forever.
// Revision : 1.0 - initial release
// ============================================================================
module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    busy
);

    localparam int c_strb_w = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    // Elaboration-time guard against illegal configurations.
    if (TIMEOUT_CYCLES < 1 ||
        !(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_param_check
        $error("apb_requester: illegal DATA_WIDTH or TIMEOUT_CYCLES");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_psel;
    logic                  w_penable;
    logic                  w_cmd_ready;
    logic                  w_handshake;
    logic                  w_complete;
    logic                  w_timeout;

    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [c_strb_w-1:0]   r_pstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;

    assign w_handshake = cmd_valid && w_cmd_ready;
    assign w_complete  = (r_state == S_ACCESS) && PREADY;

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_cmd_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (PREADY || w_timeout) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, request and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_complete || w_timeout;
            if (w_handshake) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
                // Reads present all-zero strobes on the bus.
                r_pstrb  <= cmd_write ? cmd_strb : '0;
            end
            if (w_complete) begin
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                r_rsp_error <= PSLVERR;
            end else if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_error <= 1'b1;
            end
        end
    end

`ifdef APB_REQUESTER_TIMEOUT_EN
    // Counts not-ready ACCESS cycles. The limit fires on the last not-ready
    // cycle, so a PREADY arriving in that cycle completes normally.
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_rsp_timeout;

    assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_wait_cnt == c_limit);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wait_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_ACCESS && !PREADY) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_complete) begin
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = w_cmd_ready;
    assign busy      = (r_state != S_IDLE);
    assign PSEL      = w_psel;
    assign PENABLE   = w_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire
